// File: rtl/dcache_port_ctrl_if.sv
// SQ/LSU-facing and memory-facing signal bundle for dcache_port_ctrl.
// slave is the controller's view; master is the environment (SQ, LSU, memory).
interface dcache_port_ctrl_if;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_value;
  logic [1:0]  st_size;
  logic        dcache_store_stall;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_resp_valid;
  logic [31:0] ld_resp_data;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_be;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;

  modport slave (
    input  st_valid, st_addr, st_value, st_size, ld_valid, ld_addr,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output dcache_store_stall, ld_resp_valid, ld_resp_data,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be
  );

  modport master (
    output st_valid, st_addr, st_value, st_size, ld_valid, ld_addr,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  dcache_store_stall, ld_resp_valid, ld_resp_data,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be
  );
endinterface

// File: rtl/dcache_port_ctrl.sv
// Direct-mapped write-through, no-write-allocate data cache with a single-outstanding-read
// memory port. Define DCACHE_PORT_STATS_EN to add saturating hit/miss/store counters.
module dcache_port_ctrl #(
  parameter int unsigned NUM_LINES  = 32,
  parameter int unsigned LINE_BYTES = 8
) (
  input  logic                clock,
  input  logic                reset,
`ifdef DCACHE_PORT_STATS_EN
  output logic [31:0]         stat_ld_hit,
  output logic [31:0]         stat_ld_miss,
  output logic [31:0]         stat_st,
`endif
  dcache_port_ctrl_if.slave   bus
);
  localparam int unsigned OffW = $clog2(LINE_BYTES);
  localparam int unsigned IdxW = $clog2(NUM_LINES);
  localparam int unsigned TagW = 32 - OffW - IdxW;

  typedef enum logic [1:0] {StIdle, StRdReq, StRdWait, StRdDone} state_e;

  state_e               state_q, state_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [31:2]          miss_addr_q, miss_addr_d;
  logic [TagW-1:0]      tag_q [NUM_LINES];
  logic [63:0]          data_q [NUM_LINES];

  logic [IdxW-1:0] st_idx, ld_idx, miss_idx, wr_idx;
  logic            st_hit, ld_hit, is_idle, st_accept, ld_hit_resp, ld_miss, fill, wr_en;
  logic [7:0]      st_be;
  logic [63:0]     st_wdata, line_d;
  logic            unused_ld_lsb;

  assign unused_ld_lsb = ^bus.ld_addr[1:0];

  assign st_idx   = bus.st_addr[OffW +: IdxW];
  assign ld_idx   = bus.ld_addr[OffW +: IdxW];
  assign miss_idx = miss_addr_q[OffW +: IdxW];
  assign st_hit   = valid_q[st_idx] && (tag_q[st_idx] == bus.st_addr[31 -: TagW]);
  assign ld_hit   = valid_q[ld_idx] && (tag_q[ld_idx] == bus.ld_addr[31 -: TagW]);

  assign is_idle     = (state_q == StIdle) && !reset;
  assign st_accept   = is_idle && bus.st_valid && bus.mem_req_ready;
  assign ld_hit_resp = is_idle && bus.ld_valid && ld_hit;
  assign ld_miss     = is_idle && bus.ld_valid && !ld_hit;
  assign fill        = (state_q == StRdWait) && bus.mem_resp_valid && !reset;

  // Replicating the value across the line puts it in every candidate lane; be selects one.
  always_comb begin
    st_be    = '0;
    st_wdata = {2{bus.st_value}};
    unique case (bus.st_size)
      2'd0: begin
        st_be    = 8'h01 << bus.st_addr[2:0];
        st_wdata = {8{bus.st_value[7:0]}};
      end
      2'd1: begin
        st_be    = 8'h03 << {bus.st_addr[2:1], 1'b0};
        st_wdata = {4{bus.st_value[15:0]}};
      end
      2'd2:    st_be = 8'h0F << {bus.st_addr[2], 2'b00};
      default: st_be = '0;
    endcase
  end

  always_comb begin
    bus.dcache_store_stall = bus.st_valid && !st_accept && !reset;
    bus.ld_resp_valid      = 1'b0;
    bus.ld_resp_data       = '0;
    if (!reset && state_q == StRdDone) begin
      bus.ld_resp_valid = 1'b1;
      bus.ld_resp_data  = miss_addr_q[2] ? data_q[miss_idx][63:32] : data_q[miss_idx][31:0];
    end else if (ld_hit_resp) begin
      // Reads the pre-store line; same-word forwarding is the SQ's job.
      bus.ld_resp_valid = 1'b1;
      bus.ld_resp_data  = bus.ld_addr[2] ? data_q[ld_idx][63:32] : data_q[ld_idx][31:0];
    end

    bus.mem_req_valid = 1'b0;
    bus.mem_req_we    = 1'b0;
    bus.mem_req_addr  = '0;
    bus.mem_req_wdata = '0;
    bus.mem_req_be    = '0;
    if (!reset) begin
      if (state_q == StIdle && bus.st_valid) begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_we    = 1'b1;
        bus.mem_req_addr  = bus.st_addr;
        bus.mem_req_wdata = st_wdata;
        bus.mem_req_be    = st_be;
      end else if (state_q == StRdReq) begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_addr  = {miss_addr_q[31:3], 3'b000};
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    valid_d     = valid_q;
    wr_en       = 1'b0;
    wr_idx      = st_idx;
    line_d      = data_q[st_idx];
    for (int i = 0; i < 8; i++) begin
      if (st_be[i]) line_d[8*i +: 8] = st_wdata[8*i +: 8];
    end
    if (st_accept && st_hit && (st_be != 8'h00)) wr_en = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (ld_miss) begin
          state_d     = StRdReq;
          miss_addr_d = bus.ld_addr[31:2];
        end
      end
      StRdReq:  if (bus.mem_req_ready) state_d = StRdWait;
      StRdWait: if (bus.mem_resp_valid) state_d = StRdDone;
      StRdDone: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    if (fill) begin
      wr_en            = 1'b1;
      wr_idx           = miss_idx;
      line_d           = bus.mem_resp_data;
      valid_d[miss_idx] = 1'b1;
    end
  end

`ifdef DCACHE_PORT_STATS_EN
  logic [31:0] stat_ld_hit_q, stat_ld_hit_d;
  logic [31:0] stat_ld_miss_q, stat_ld_miss_d;
  logic [31:0] stat_st_q, stat_st_d;

  always_comb begin
    stat_ld_hit_d  = stat_ld_hit_q;
    stat_ld_miss_d = stat_ld_miss_q;
    stat_st_d      = stat_st_q;
    if (ld_hit_resp && stat_ld_hit_q != 32'hFFFF_FFFF) stat_ld_hit_d = stat_ld_hit_q + 32'd1;
    if (ld_miss && stat_ld_miss_q != 32'hFFFF_FFFF)    stat_ld_miss_d = stat_ld_miss_q + 32'd1;
    if (st_accept && stat_st_q != 32'hFFFF_FFFF)       stat_st_d = stat_st_q + 32'd1;
  end

  assign stat_ld_hit  = stat_ld_hit_q;
  assign stat_ld_miss = stat_ld_miss_q;
  assign stat_st      = stat_st_q;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      valid_q     <= '0;
      miss_addr_q <= '0;
`ifdef DCACHE_PORT_STATS_EN
      stat_ld_hit_q  <= '0;
      stat_ld_miss_q <= '0;
      stat_st_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      miss_addr_q <= miss_addr_d;
`ifdef DCACHE_PORT_STATS_EN
      stat_ld_hit_q  <= stat_ld_hit_d;
      stat_ld_miss_q <= stat_ld_miss_d;
      stat_st_q      <= stat_st_d;
`endif
    end
  end

  // Line storage needs no reset: valid_q gates every use of it.
  always_ff @(posedge clock) begin
    if (wr_en) data_q[wr_idx] <= line_d;
    if (fill)  tag_q[miss_idx] <= miss_addr_q[31 -: TagW];
  end
endmodule

// File: tb/tb_dcache_port_ctrl.sv
// Directed bench for dcache_port_ctrl: stimulus queues expected load responses and
// memory requests, a negedge monitor pops and compares whenever the DUT presents them.
module tb_dcache_port_ctrl;
  logic clock;
  logic reset;
  dcache_port_ctrl_if bus ();

`ifdef DCACHE_PORT_STATS_EN
  logic [31:0] stat_ld_hit, stat_ld_miss, stat_st;
`endif

  dcache_port_ctrl dut (
    .clock        (clock),
    .reset        (reset),
`ifdef DCACHE_PORT_STATS_EN
    .stat_ld_hit  (stat_ld_hit),
    .stat_ld_miss (stat_ld_miss),
    .stat_st      (stat_st),
`endif
    .bus          (bus)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [7:0]  be;
    logic [63:0] wdata;
  } mem_exp_t;

  logic [31:0] exp_ld_q [$];
  mem_exp_t    exp_mem_q [$];
  int n_cmp = 0;
  int n_err = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] lane_mask(input logic [7:0] be);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  always @(negedge clock) begin
    if (bus.ld_resp_valid) begin
      if (exp_ld_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_ld_resp: got data %h expected no response", bus.ld_resp_data);
      end else begin
        check("ld_resp_data", bus.ld_resp_data, exp_ld_q.pop_front());
      end
    end
    if (bus.mem_req_valid && bus.mem_req_ready) begin
      if (exp_mem_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_mem_req: got we %b addr %h expected no request",
                 bus.mem_req_we, bus.mem_req_addr);
      end else begin
        mem_exp_t e;
        e = exp_mem_q.pop_front();
        check("mem_req_we", bus.mem_req_we, e.we);
        check("mem_req_addr", bus.mem_req_addr, e.addr);
        check("mem_req_be", bus.mem_req_be, e.be);
        check("mem_req_wdata", bus.mem_req_wdata & lane_mask(e.be), e.wdata);
      end
    end
  end

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic load_miss(input logic [31:0] a, input logic [63:0] line, input logic [31:0] w);
    exp_mem_q.push_back('{1'b0, {a[31:3], 3'b000}, 8'h00, 64'h0});
    exp_ld_q.push_back(w);
    bus.ld_valid = 1'b1;
    bus.ld_addr = a;
    bus.mem_req_ready = 1'b1;
    @(negedge clock);
    check("miss_no_hit", bus.ld_resp_valid, 1'b0);
    step;
    @(negedge clock);
    check("rd_req_valid", bus.mem_req_valid, 1'b1);
    step;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data = line;
    step;
    bus.mem_resp_valid = 1'b0;
    @(negedge clock);
    check("fill_resp_valid", bus.ld_resp_valid, 1'b1);
    step;
    bus.ld_valid = 1'b0;
  endtask

  task automatic load_hit(input logic [31:0] a, input logic [31:0] w);
    exp_ld_q.push_back(w);
    bus.ld_valid = 1'b1;
    bus.ld_addr = a;
    @(negedge clock);
    check("hit_same_cycle", bus.ld_resp_valid, 1'b1);
    step;
    bus.ld_valid = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] v, input logic [1:0] sz,
                       input logic [7:0] be, input logic [63:0] wd);
    exp_mem_q.push_back('{1'b1, a, be, wd});
    bus.st_valid = 1'b1;
    bus.st_addr = a;
    bus.st_value = v;
    bus.st_size = sz;
    bus.mem_req_ready = 1'b1;
    @(negedge clock);
    check("store_no_stall", bus.dcache_store_stall, 1'b0);
    step;
    bus.st_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.st_valid = 1'b1;
    bus.st_addr = 32'h0;
    bus.st_value = 32'h0;
    bus.st_size = 2'd2;
    bus.ld_valid = 1'b1;
    bus.ld_addr = 32'h100;
    bus.mem_req_ready = 1'b1;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data = 64'h0;
    step;
    step;
    @(negedge clock);
    check("rst_stall", bus.dcache_store_stall, 1'b0);
    check("rst_ld_resp", bus.ld_resp_valid, 1'b0);
    check("rst_mem_req", bus.mem_req_valid, 1'b0);
    step;
    reset = 1'b0;
    bus.st_valid = 1'b0;
    bus.ld_valid = 1'b0;

    // Fill line 0x100, then hit the other word.
    load_miss(32'h100, 64'h1122_3344_5566_7788, 32'h5566_7788);
    load_hit(32'h104, 32'h1122_3344);

    // Byte store hit merges into the line.
    store(32'h105, 32'h0000_00AB, 2'd0, 8'h20, 64'h0000_AB00_0000_0000);
    load_hit(32'h104, 32'h1122_AB44);

    // Word store miss stalled by memory for three cycles; no allocation.
    exp_mem_q.push_back('{1'b1, 32'h2000, 8'h0F, 64'h0000_0000_DEAD_BEEF});
    bus.st_valid = 1'b1;
    bus.st_addr = 32'h2000;
    bus.st_value = 32'hDEAD_BEEF;
    bus.st_size = 2'd2;
    bus.mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("stall_not_ready", bus.dcache_store_stall, 1'b1);
      step;
    end
    bus.mem_req_ready = 1'b1;
    @(negedge clock);
    check("accept_when_ready", bus.dcache_store_stall, 1'b0);
    step;
    bus.st_valid = 1'b0;
    load_miss(32'h2000, 64'hCAFE_F00D_1234_5678, 32'h1234_5678);

    // Store presented during a fill is held until the controller is back in idle;
    // ld_valid drops mid-fill and the response still arrives.
    exp_mem_q.push_back('{1'b0, 32'h408, 8'h00, 64'h0});
    exp_ld_q.push_back(32'h0506_0708);
    bus.ld_valid = 1'b1;
    bus.ld_addr = 32'h408;
    @(negedge clock);
    check("miss_no_hit", bus.ld_resp_valid, 1'b0);
    step;
    bus.st_valid = 1'b1;
    bus.st_addr = 32'h40C;
    bus.st_value = 32'h55AA_55AA;
    bus.st_size = 2'd2;
    @(negedge clock);
    check("stall_rd_req", bus.dcache_store_stall, 1'b1);
    step;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data = 64'h0102_0304_0506_0708;
    bus.ld_valid = 1'b0;
    @(negedge clock);
    check("stall_rd_wait", bus.dcache_store_stall, 1'b1);
    step;
    bus.mem_resp_valid = 1'b0;
    @(negedge clock);
    check("stall_rd_done", bus.dcache_store_stall, 1'b1);
    check("resp_after_ld_drop", bus.ld_resp_valid, 1'b1);
    step;
    exp_mem_q.push_back('{1'b1, 32'h40C, 8'hF0, 64'h55AA_55AA_0000_0000});
    @(negedge clock);
    check("stall_released", bus.dcache_store_stall, 1'b0);
    step;
    bus.st_valid = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data = 64'h0;
    step;
    bus.mem_resp_valid = 1'b0;
    load_hit(32'h40C, 32'h55AA_55AA);
    load_hit(32'h408, 32'h0506_0708);

    // Same-cycle load miss and half store: store first, then the line read; reset mid-fill.
    exp_mem_q.push_back('{1'b1, 32'h300, 8'h03, 64'h0000_0000_0000_BEEF});
    exp_mem_q.push_back('{1'b0, 32'h300, 8'h00, 64'h0});
    bus.st_valid = 1'b1;
    bus.st_addr = 32'h300;
    bus.st_value = 32'h0000_BEEF;
    bus.st_size = 2'd1;
    bus.ld_valid = 1'b1;
    bus.ld_addr = 32'h300;
    @(negedge clock);
    check("combo_store_no_stall", bus.dcache_store_stall, 1'b0);
    check("combo_miss", bus.ld_resp_valid, 1'b0);
    step;
    bus.st_valid = 1'b0;
    step;
    reset = 1'b1;
    bus.st_valid = 1'b1;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data = 64'hDEAD_DEAD_DEAD_DEAD;
    @(negedge clock);
    check("mid_rst_mem_req", bus.mem_req_valid, 1'b0);
    check("mid_rst_ld_resp", bus.ld_resp_valid, 1'b0);
    check("mid_rst_stall", bus.dcache_store_stall, 1'b0);
    step;
    reset = 1'b0;
    bus.st_valid = 1'b0;
    load_miss(32'h300, 64'h7777_6666_5555_4444, 32'h5555_4444);
    load_miss(32'h408, 64'h0102_0304_0506_0708, 32'h0506_0708);

    // Fresh reset, then 1 miss, 3 stores (hit byte, double, miss word), 2 hits.
    reset = 1'b1;
    step;
    reset = 1'b0;
    load_miss(32'h500, 64'hA1A2_A3A4_B1B2_B3B4, 32'hB1B2_B3B4);
    store(32'h503, 32'h0000_0077, 2'd0, 8'h08, 64'h0000_0000_7700_0000);
    store(32'h504, 32'hFFFF_FFFF, 2'd3, 8'h00, 64'h0);
    store(32'h900, 32'h1357_2468, 2'd2, 8'h0F, 64'h0000_0000_1357_2468);
    load_hit(32'h500, 32'h77B2_B3B4);
    load_hit(32'h504, 32'hA1A2_A3A4);
`ifdef DCACHE_PORT_STATS_EN
    @(negedge clock);
    check("stat_ld_hit", stat_ld_hit, 32'd2);
    check("stat_ld_miss", stat_ld_miss, 32'd1);
    check("stat_st", stat_st, 32'd3);
`endif

    step;
    @(negedge clock);
    check("ld_queue_drained", exp_ld_q.size(), 0);
    check("mem_queue_drained", exp_mem_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
